// File: rtl/can_id_filter_bank_if.sv
// Bus bundle for can_id_filter_bank: serial sample inputs, filter configuration and match results.
interface can_id_filter_bank_if #(
  parameter int unsigned ID_WIDTH    = 11,
  parameter int unsigned NUM_FILTERS = 4
);
  localparam int unsigned IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int unsigned CFG_W = NUM_FILTERS * ID_WIDTH;

  logic                   enable;
  logic                   abortIn;
  logic                   dIn;
  logic                   samplePulse;
  logic [CFG_W-1:0]       filterId;
  logic [CFG_W-1:0]       filterMask;
  logic [NUM_FILTERS-1:0] filterEn;
  logic                   idCheckComplete;
  logic                   idMatch;
  logic [NUM_FILTERS-1:0] matchVec;
  logic [IDX_W-1:0]       matchIdx;
  logic [ID_WIDTH-1:0]    rxId;
  logic                   sampleOverrun;

  modport master (
    output enable, abortIn, dIn, samplePulse, filterId, filterMask, filterEn,
    input  idCheckComplete, idMatch, matchVec, matchIdx, rxId, sampleOverrun
  );

  modport slave (
    input  enable, abortIn, dIn, samplePulse, filterId, filterMask, filterEn,
    output idCheckComplete, idMatch, matchVec, matchIdx, rxId, sampleOverrun
  );
endinterface

// File: rtl/can_id_filter_bank.sv
// Majority-voted serial CAN identifier assembly followed by a bank of masked acceptance filters.
module can_id_filter_bank #(
  parameter int unsigned ID_WIDTH    = 11,
  parameter int unsigned NUM_FILTERS = 4,
  parameter int unsigned SAMPLES     = 3
) (
  input logic                clk,
  input logic                resetN,
  can_id_filter_bank_if.slave bus
);
  localparam int unsigned IDX_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int unsigned SC_W  = $clog2(SAMPLES + 1);
  localparam int unsigned BC_W  = $clog2(ID_WIDTH + 1);
  localparam int unsigned CFG_W = NUM_FILTERS * ID_WIDTH;
  localparam bit          SINGLE_SAMPLE = (SAMPLES == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_COMMIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [SC_W-1:0]        samp_cnt_q;
  logic [SC_W-1:0]        ones_q;
  logic [BC_W-1:0]        bit_cnt_q;
  logic [ID_WIDTH-1:0]    rx_id_q;
  logic [CFG_W-1:0]       cfg_id_q;
  logic [CFG_W-1:0]       cfg_mask_q;
  logic [NUM_FILTERS-1:0] cfg_en_q;
  logic                   complete_q;
  logic                   match_q;
  logic [NUM_FILTERS-1:0] match_vec_q;
  logic [IDX_W-1:0]       match_idx_q;
  logic                   overrun_q;

  logic                   maj_c;
  logic [NUM_FILTERS-1:0] match_vec_d;
  logic [IDX_W-1:0]       match_idx_d;

  assign maj_c = (ones_q > SC_W'(SAMPLES / 2));

  // Filter evaluation against the frozen configuration; lowest matching index wins.
  always_comb begin
    match_vec_d = '0;
    match_idx_d = '0;
    for (int i = 0; i < int'(NUM_FILTERS); i++) begin
      match_vec_d[i] = cfg_en_q[i] &
                       ~|((rx_id_q ^ cfg_id_q[i*ID_WIDTH +: ID_WIDTH]) &
                          cfg_mask_q[i*ID_WIDTH +: ID_WIDTH]);
    end
    for (int i = int'(NUM_FILTERS) - 1; i >= 0; i--) begin
      if (match_vec_d[i]) match_idx_d = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      samp_cnt_q  <= '0;
      ones_q      <= '0;
      bit_cnt_q   <= '0;
      rx_id_q     <= '0;
      cfg_id_q    <= '0;
      cfg_mask_q  <= '0;
      cfg_en_q    <= '0;
      complete_q  <= 1'b0;
      match_q     <= 1'b0;
      match_vec_q <= '0;
      match_idx_q <= '0;
      overrun_q   <= 1'b0;
    end else if ((state_q != S_IDLE) && (bus.abortIn || !bus.enable)) begin
      // Abandoned frame: drop everything, the config is relatched in IDLE.
      state_q     <= S_IDLE;
      samp_cnt_q  <= '0;
      ones_q      <= '0;
      bit_cnt_q   <= '0;
      rx_id_q     <= '0;
      complete_q  <= 1'b0;
      match_q     <= 1'b0;
      match_vec_q <= '0;
      match_idx_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cfg_id_q   <= bus.filterId;
          cfg_mask_q <= bus.filterMask;
          cfg_en_q   <= bus.filterEn;
          if (bus.enable && bus.samplePulse) begin
            ones_q     <= SC_W'(bus.dIn);
            samp_cnt_q <= SC_W'(1);
            state_q    <= SINGLE_SAMPLE ? S_COMMIT : S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (bus.samplePulse) begin
            ones_q     <= ones_q + SC_W'(bus.dIn);
            samp_cnt_q <= samp_cnt_q + SC_W'(1);
            if (samp_cnt_q == SC_W'(SAMPLES - 1)) state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          rx_id_q    <= {rx_id_q[ID_WIDTH-2:0], maj_c};
          bit_cnt_q  <= bit_cnt_q + BC_W'(1);
          samp_cnt_q <= '0;
          ones_q     <= '0;
          if (bus.samplePulse) overrun_q <= 1'b1;
          state_q    <= (bit_cnt_q == BC_W'(ID_WIDTH - 1)) ? S_CHECK : S_SAMPLE;
        end
        S_CHECK: begin
          match_vec_q <= match_vec_d;
          match_q     <= |match_vec_d;
          match_idx_q <= match_idx_d;
          complete_q  <= 1'b1;
          if (bus.samplePulse) overrun_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.idCheckComplete = complete_q;
  assign bus.idMatch         = match_q;
  assign bus.matchVec        = match_vec_q;
  assign bus.matchIdx        = match_idx_q;
  assign bus.rxId            = rx_id_q;
  assign bus.sampleOverrun   = overrun_q;
endmodule

// File: tb/tb_can_id_filter_bank.sv
// Randomized self-checking bench for can_id_filter_bank: standard (11-bit) and extended (29-bit) instances.
module tb_can_id_filter_bank;
  localparam int SAMPLES = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetN, enable, abortIn, dIn, samplePulse;
  logic [10:0] f_id[4], f_mask[4], s_id[4], s_mask[4];
  logic [3:0]  f_en, s_en;
  logic [28:0] g_id[2], g_mask[2], t_id[2], t_mask[2];
  logic [1:0]  g_en, t_en;
  logic [28:0] exp_rx;
  int n_checks = 0;
  int n_fail   = 0;

  can_id_filter_bank_if #(.ID_WIDTH(11), .NUM_FILTERS(4)) b11 ();
  can_id_filter_bank_if #(.ID_WIDTH(29), .NUM_FILTERS(2)) b29 ();

  assign b11.enable = enable;       assign b29.enable = enable;
  assign b11.abortIn = abortIn;     assign b29.abortIn = abortIn;
  assign b11.dIn = dIn;             assign b29.dIn = dIn;
  assign b11.samplePulse = samplePulse; assign b29.samplePulse = samplePulse;
  assign b11.filterId   = {f_id[3], f_id[2], f_id[1], f_id[0]};
  assign b11.filterMask = {f_mask[3], f_mask[2], f_mask[1], f_mask[0]};
  assign b11.filterEn   = f_en;
  assign b29.filterId   = {g_id[1], g_id[0]};
  assign b29.filterMask = {g_mask[1], g_mask[0]};
  assign b29.filterEn   = g_en;

  can_id_filter_bank #(.ID_WIDTH(11), .NUM_FILTERS(4), .SAMPLES(SAMPLES)) dut11 (
    .clk(clk), .resetN(resetN), .bus(b11));
  can_id_filter_bank #(.ID_WIDTH(29), .NUM_FILTERS(2), .SAMPLES(SAMPLES)) dut29 (
    .clk(clk), .resetN(resetN), .bus(b29));

  // Reference: filter i accepts when enabled and the ID agrees with it on every masked bit.
  function automatic logic [3:0] model_vec11(input logic [10:0] rx);
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = s_en[i] && ((rx & s_mask[i]) == (s_id[i] & s_mask[i]));
    return v;
  endfunction

  function automatic logic [1:0] model_vec29(input logic [28:0] rx);
    logic [1:0] v;
    for (int i = 0; i < 2; i++) v[i] = t_en[i] && ((rx & t_mask[i]) == (t_id[i] & t_mask[i]));
    return v;
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // mode 0: clean samples, 1: middle sample inverted, 2: random samples.
  task automatic send_frame(input int nbits, input logic [28:0] id, input int mode,
                            input int abort_bit, input int stop_bit, input int inject_bit,
                            input int scramble_bit);
    logic b, samp;
    int ones;
    exp_rx = '0;
    s_id = f_id; s_mask = f_mask; s_en = f_en;
    t_id = g_id; t_mask = g_mask; t_en = g_en;
    @(negedge clk);
    enable = 1'b1;
    abortIn = 1'b0;
    for (int bi = 0; bi < nbits; bi++) begin
      if (bi == abort_bit) begin
        abortIn = 1'b1;
        @(negedge clk);
        abortIn = 1'b0;
        return;
      end
      if (bi == stop_bit) return;
      if (bi == scramble_bit) begin
        for (int f = 0; f < 4; f++) begin
          f_id[f] = 11'($urandom); f_mask[f] = 11'($urandom);
        end
        f_en = 4'($urandom);
      end
      b = id[nbits-1-bi];
      ones = 0;
      for (int s = 0; s < SAMPLES; s++) begin
        case (mode)
          0: samp = b;
          1: samp = (s == 1) ? ~b : b;
          default: samp = 1'($urandom_range(0, 1));
        endcase
        ones += int'(samp);
        dIn = samp;
        samplePulse = 1'b1;
        @(negedge clk);
        if (bi == inject_bit && s == SAMPLES - 1) begin
          dIn = ~dIn;
          @(negedge clk);
        end
        samplePulse = 1'b0;
        dIn = 1'($urandom);
        if (!(bi == nbits - 1 && s == SAMPLES - 1)) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      exp_rx = {exp_rx[27:0], (ones > SAMPLES / 2)};
    end
  endtask

  task automatic wait_done(input bit ext, output int lat);
    lat = 0;
    while (!(ext ? b29.idCheckComplete : b11.idCheckComplete) && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    enable = 1'b0;
    abortIn = 1'b0;
    samplePulse = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetN = 1'b0; enable = 1'b0; abortIn = 1'b0; samplePulse = 1'b0; dIn = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.matchIdx, b11.rxId, b11.sampleOverrun} !== '0) begin
      n_fail++;
      $display("FAIL reset11: got rx=%h vec=%b cmp=%b expected all zero", b11.rxId, b11.matchVec, b11.idCheckComplete);
    end
    n_checks++;
    if ({b29.idCheckComplete, b29.idMatch, b29.matchVec, b29.matchIdx, b29.rxId, b29.sampleOverrun} !== '0) begin
      n_fail++;
      $display("FAIL reset29: got rx=%h vec=%b cmp=%b expected all zero", b29.rxId, b29.matchVec, b29.idCheckComplete);
    end
    resetN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    for (int f = 0; f < 4; f++) begin f_id[f] = 11'($urandom); f_mask[f] = 11'($urandom); end
    f_id[1] = 11'h123; f_mask[1] = 11'h7FF; f_en = 4'b0010;
    send_frame(11, 29'h123, 0, -1, -1, -1, -1);
    wait_done(1'b0, lat);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d expected 2", lat); end
    n_checks++;
    if (b11.rxId !== 11'h123) begin n_fail++; $display("FAIL basic_rx: got %h expected 123", b11.rxId); end
    n_checks++;
    if ({b11.idMatch, b11.matchVec, b11.matchIdx} !== {1'b1, 4'b0010, 2'd1}) begin
      n_fail++;
      $display("FAIL basic_match: got m=%b vec=%b idx=%0d expected m=1 vec=0010 idx=1", b11.idMatch, b11.matchVec, b11.matchIdx);
    end
    for (int k = 0; k < 3; k++) begin
      samplePulse = 1'b1; dIn = 1'($urandom); @(negedge clk);
      samplePulse = 1'b0; @(negedge clk);
    end
    n_checks++;
    if ({b11.idCheckComplete, b11.sampleOverrun, b11.rxId} !== {1'b1, 1'b0, 11'h123}) begin
      n_fail++;
      $display("FAIL done_hold: got cmp=%b ovr=%b rx=%h expected cmp=1 ovr=0 rx=123", b11.idCheckComplete, b11.sampleOverrun, b11.rxId);
    end
    end_frame();
    n_checks++;
    if ({b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.rxId} !== '0) begin
      n_fail++;
      $display("FAIL disable_done: got cmp=%b m=%b rx=%h expected all zero", b11.idCheckComplete, b11.idMatch, b11.rxId);
    end
  endtask

  task automatic test_majority();
    int lat;
    logic [10:0] id;
    logic [3:0] ev;
    send_frame(11, 29'h555, 1, -1, -1, -1, -1);
    wait_done(1'b0, lat);
    n_checks++;
    if (b11.rxId !== 11'h555) begin n_fail++; $display("FAIL majority_555: got %h expected 555", b11.rxId); end
    end_frame();
    for (int k = 0; k < 6; k++) begin
      id = 11'($urandom);
      for (int f = 0; f < 4; f++) begin
        f_mask[f] = 11'($urandom);
        f_id[f] = ($urandom_range(0, 1) == 1) ? (id ^ (11'($urandom) & ~f_mask[f])) : 11'($urandom);
      end
      f_mask[k % 4] = (k == 3) ? 11'h000 : f_mask[k % 4];
      f_en = 4'($urandom);
      send_frame(11, 29'(id), 1 + (k % 2), -1, -1, -1, -1);
      wait_done(1'b0, lat);
      ev = model_vec11(exp_rx[10:0]);
      n_checks++;
      if (b11.rxId !== exp_rx[10:0]) begin n_fail++; $display("FAIL rand_rx[%0d]: got %h expected %h", k, b11.rxId, exp_rx[10:0]); end
      n_checks++;
      if ({b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.matchIdx} !== {1'b1, |ev, ev, 2'(lowest(ev))}) begin
        n_fail++;
        $display("FAIL rand_match[%0d]: got c=%b m=%b vec=%b idx=%0d expected c=1 m=%b vec=%b idx=%0d",
                 k, b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.matchIdx, |ev, ev, lowest(ev));
      end
      end_frame();
    end
  endtask

  task automatic test_masks();
    int lat;
    f_id[0] = 11'h120; f_mask[0] = 11'h7F0;
    f_id[1] = 11'h12A; f_mask[1] = 11'h7FF;
    f_id[2] = 11'h123; f_mask[2] = 11'h7FF;
    f_id[3] = 11'h000; f_mask[3] = 11'h000;
    f_en = 4'b0101;
    send_frame(11, 29'h12A, 0, -1, -1, -1, 5);
    wait_done(1'b0, lat);
    n_checks++;
    if ({b11.idMatch, b11.matchVec, b11.matchIdx} !== {1'b1, 4'b0001, 2'd0}) begin
      n_fail++;
      $display("FAIL mask_f0: got m=%b vec=%b idx=%0d expected m=1 vec=0001 idx=0", b11.idMatch, b11.matchVec, b11.matchIdx);
    end
    end_frame();
    f_id[0] = 11'h120; f_mask[0] = 11'h7F0;
    f_id[1] = 11'h12A; f_mask[1] = 11'h7FF;
    f_id[2] = 11'h123; f_mask[2] = 11'h7FF;
    f_en = 4'b0100;
    send_frame(11, 29'h12A, 0, -1, -1, -1, -1);
    wait_done(1'b0, lat);
    n_checks++;
    if ({b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.matchIdx} !== {1'b1, 1'b0, 4'b0000, 2'd0}) begin
      n_fail++;
      $display("FAIL mask_f0_off: got c=%b m=%b vec=%b idx=%0d expected c=1 m=0 vec=0000 idx=0",
               b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.matchIdx);
    end
    end_frame();
  endtask

  task automatic test_ext();
    int lat;
    logic [1:0] ev;
    g_id[0] = 29'h1ABCDEF0; g_mask[0] = 29'h1FFFFFFF;
    g_id[1] = 29'($urandom); g_mask[1] = 29'($urandom);
    g_en = 2'b11;
    send_frame(29, 29'h1ABCDEF0, 0, -1, -1, -1, -1);
    wait_done(1'b1, lat);
    ev = model_vec29(exp_rx);
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("FAIL ext_latency: got %0d expected 2", lat); end
    n_checks++;
    if (b29.rxId !== 29'h1ABCDEF0) begin n_fail++; $display("FAIL ext_rx: got %h expected 1abcdef0", b29.rxId); end
    n_checks++;
    if ({b29.idMatch, b29.matchVec, b29.matchIdx} !== {1'b1, ev, 1'b0}) begin
      n_fail++;
      $display("FAIL ext_match: got m=%b vec=%b idx=%0d expected m=1 vec=%b idx=0", b29.idMatch, b29.matchVec, b29.matchIdx, ev);
    end
    end_frame();
    send_frame(29, 29'h1ABCDEF0, 0, 14, -1, -1, -1);
    n_checks++;
    if ({b29.idCheckComplete, b29.idMatch, b29.matchVec, b29.rxId, b29.sampleOverrun} !== '0) begin
      n_fail++;
      $display("FAIL ext_abort29: got c=%b rx=%h expected all zero", b29.idCheckComplete, b29.rxId);
    end
    n_checks++;
    if ({b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.rxId} !== '0) begin
      n_fail++;
      $display("FAIL ext_abort11: got c=%b rx=%h expected all zero", b11.idCheckComplete, b11.rxId);
    end
    send_frame(29, 29'h1ABCDEF0, 2, -1, -1, -1, -1);
    wait_done(1'b1, lat);
    ev = model_vec29(exp_rx);
    n_checks++;
    if ({b29.idCheckComplete, b29.rxId, b29.idMatch, b29.matchVec} !== {1'b1, exp_rx, |ev, ev}) begin
      n_fail++;
      $display("FAIL ext_after_abort: got c=%b rx=%h m=%b vec=%b expected c=1 rx=%h m=%b vec=%b",
               b29.idCheckComplete, b29.rxId, b29.idMatch, b29.matchVec, exp_rx, |ev, ev);
    end
    end_frame();
  endtask

  task automatic test_overrun();
    int lat;
    logic [10:0] id;
    id = 11'($urandom);
    send_frame(11, 29'(id), 0, -1, -1, 4, -1);
    wait_done(1'b0, lat);
    n_checks++;
    if ({b11.rxId, b11.sampleOverrun} !== {id, 1'b1}) begin
      n_fail++;
      $display("FAIL overrun_set: got rx=%h ovr=%b expected rx=%h ovr=1", b11.rxId, b11.sampleOverrun, id);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if ({b11.idCheckComplete, b11.sampleOverrun} !== 2'b11) begin
      n_fail++;
      $display("FAIL overrun_hold: got c=%b ovr=%b expected c=1 ovr=1", b11.idCheckComplete, b11.sampleOverrun);
    end
    end_frame();
    n_checks++;
    if (b11.sampleOverrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", b11.sampleOverrun); end
  endtask

  task automatic test_reset_mid();
    int lat;
    send_frame(11, 29'h7FF, 0, -1, 5, -1, -1);
    n_checks++;
    if (b11.rxId !== 11'h01F) begin n_fail++; $display("FAIL partial_rx: got %h expected 01f", b11.rxId); end
    resetN = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b11.idCheckComplete, b11.rxId, b11.sampleOverrun, b29.rxId} !== '0) begin
      n_fail++;
      $display("FAIL reset_sample: got rx11=%h rx29=%h expected zero", b11.rxId, b29.rxId);
    end
    resetN = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    f_id[3] = 11'h2AA; f_mask[3] = 11'h000; f_en = 4'b1000;
    send_frame(11, 29'h2AA, 0, -1, -1, -1, -1);
    wait_done(1'b0, lat);
    n_checks++;
    if ({b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.matchIdx} !== {1'b1, 1'b1, 4'b1000, 2'd3}) begin
      n_fail++;
      $display("FAIL zero_mask: got c=%b m=%b vec=%b idx=%0d expected c=1 m=1 vec=1000 idx=3",
               b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.matchIdx);
    end
    resetN = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b11.idCheckComplete, b11.idMatch, b11.matchVec, b11.matchIdx, b11.rxId, b11.sampleOverrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_done: got c=%b m=%b rx=%h expected all zero", b11.idCheckComplete, b11.idMatch, b11.rxId);
    end
    resetN = 1'b1;
    enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int f = 0; f < 4; f++) begin f_id[f] = '0; f_mask[f] = '0; end
    for (int f = 0; f < 2; f++) begin g_id[f] = '0; g_mask[f] = '0; end
    f_en = '0; g_en = '0;
    test_reset();
    test_basic();
    test_majority();
    test_masks();
    test_ext();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
